// File: rtl/mips_debug_ctrl_pkg.sv
// Shared definitions for the mips debug front-end: widths, debounce defaults and button indices.
package mips_debug_defs;

  localparam int DEBUG_ADDR_W           = 7;
  localparam int DEBOUNCE_CYCLES_SIM    = 4;
  localparam int DEBOUNCE_CYCLES_BOARD  = 20;
  localparam int DEBOUNCE_CYCLES_DEFAULT = DEBOUNCE_CYCLES_BOARD;
  localparam int NUM_BTNS               = 5;

  typedef enum logic [2:0] {
    BTN_RUN  = 3'd0,
    BTN_STEP = 3'd1,
    BTN_IRQ  = 3'd2,
    BTN_INC  = 3'd3,
    BTN_DEC  = 3'd4
  } btn_idx_e;

endpackage

// File: rtl/mips_debug_ctrl_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      level       <= 1'b0;
      level_d     <= 1'b0;
      press_pulse <= 1'b0;
      cnt         <= '0;
    end else begin
      // stage p0/p1: metastability guard on the asynchronous button
      sync_p0     <= btn_raw;
      sync_p1     <= sync_p0;
      // stage p2: qualify level changes, then edge-detect the debounced level
      level_d     <= level;
      press_pulse <= level & ~level_d;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Board push-buttons to mips core debug controls: run/halt toggle, gated step, irq request, register select.
module mips_debug_ctrl
  import mips_debug_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 5,
  parameter int ADDR_W          = DEBUG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_irq,
  input  logic              btn_addr_inc,
  input  logic              btn_addr_dec,
  input  logic              irq_ack,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  output logic              interrupter
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_pulse;
  logic [NUM_BTNS-1:0] press;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] addr,
                                                  input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return addr + ADDR_W'(1);
      2'b01:   return addr - ADDR_W'(1);
      default: return addr;
    endcase
  endfunction

  assign btn_raw[BTN_RUN]  = btn_run;
  assign btn_raw[BTN_STEP] = btn_step;
  assign btn_raw[BTN_IRQ]  = btn_irq;
  assign btn_raw[BTN_INC]  = btn_addr_inc;
  assign btn_raw[BTN_DEC]  = btn_addr_dec;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .level      (btn_level[i]),
      .press_pulse(btn_pulse[i])
    );
  end

  // A press only counts while its button is still debounced-down.
  assign press = btn_pulse & btn_level;

  always_ff @(posedge clk) begin
    if (!rst) begin
      debug_en    <= 1'b1;
      debug_step  <= 1'b0;
      debug_addr  <= '0;
      interrupter <= 1'b0;
    end else begin
      // step is judged against debug_en before any toggle in the same cycle
      debug_step  <= press[BTN_STEP] & debug_en;
      debug_en    <= debug_en ^ press[BTN_RUN];
      interrupter <= press[BTN_IRQ] | (interrupter & ~irq_ack);
      debug_addr  <= addr_next(debug_addr, press[BTN_INC], press[BTN_DEC]);
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Bench for mips_debug_ctrl: directed scenarios plus random button activity against a behavioural model.
module tb_mips_debug_ctrl;

  localparam int D  = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    btn = '0;   // 0 run, 1 step, 2 irq, 3 inc, 4 dec
  logic          irq_ack = 1'b0;
  logic          debug_en;
  logic          debug_step;
  logic [AW-1:0] debug_addr;
  logic          interrupter;

  always #10 clk = ~clk;

  mips_debug_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .ADDR_W         (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run     (btn[0]),
    .btn_step    (btn[1]),
    .btn_irq     (btn[2]),
    .btn_addr_inc(btn[3]),
    .btn_addr_dec(btn[4]),
    .irq_ack     (irq_ack),
    .debug_en    (debug_en),
    .debug_step  (debug_step),
    .debug_addr  (debug_addr),
    .interrupter (interrupter)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: each button is a 2-sample delay line feeding a "D agreeing-in-a-row" rule;
  // a debounced rise becomes a press one cycle later, and the press acts on the core one cycle after that.
  bit          m_en = 1'b1;
  bit          m_step, m_intr;
  bit [AW-1:0] m_addr;
  bit          m_lvl[5], m_lvl_prev[5], m_press[5], m_dly_old[5], m_dly_new[5];
  int          m_run_len[5];
  int          cyc = 0;

  always @(posedge clk) begin
    bit p[5];
    cyc++;
    if (!rst) begin
      m_en = 1'b1; m_step = 1'b0; m_intr = 1'b0; m_addr = '0;
      for (int b = 0; b < 5; b++) begin
        m_lvl[b] = 0; m_lvl_prev[b] = 0; m_press[b] = 0;
        m_dly_old[b] = 0; m_dly_new[b] = 0; m_run_len[b] = 0;
      end
    end else begin
      p = m_press;
      m_step = p[1] && m_en;
      if (p[0]) m_en = !m_en;
      if (p[2]) m_intr = 1'b1;
      else if (irq_ack) m_intr = 1'b0;
      if (p[3] && !p[4]) m_addr = m_addr + 1'b1;
      else if (p[4] && !p[3]) m_addr = m_addr - 1'b1;
      for (int b = 0; b < 5; b++) begin
        m_press[b]    = m_lvl[b] && !m_lvl_prev[b];
        m_lvl_prev[b] = m_lvl[b];
        if (m_dly_old[b] != m_lvl[b]) begin
          m_run_len[b]++;
          if (m_run_len[b] == D) begin
            m_lvl[b]     = !m_lvl[b];
            m_run_len[b] = 0;
          end
        end else begin
          m_run_len[b] = 0;
        end
        m_dly_old[b] = m_dly_new[b];
        m_dly_new[b] = btn[b];
      end
    end
  end

  bit prev_step = 1'b0;
  int step_cnt  = 0;
  int step_cyc  = 0;

  always @(negedge clk) begin
    check_eq("outputs", {debug_en, debug_step, debug_addr, interrupter},
             {m_en, m_step, m_addr, m_intr});
    check_eq("step_two_cycles", 32'(debug_step & prev_step), 32'd0);
    if (debug_step) begin
      step_cnt++;
      step_cyc = cyc;
    end
    prev_step = debug_step;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cycles(12);
    btn[b] = 1'b0;
    cycles(D + 6);
  endtask

  initial begin
    int t0;
    int lat;

    // reset held for 5 cycles
    rst = 1'b0;
    cycles(5);
    check_eq("reset_state", {debug_en, debug_step, debug_addr, interrupter}, 32'h200);
    rst = 1'b1;
    cycles(3);

    // held step button: exactly one pulse, 7-8 cycles after the raw edge
    step_cnt = 0;
    t0 = cyc;
    btn[1] = 1'b1;
    cycles(20);
    btn[1] = 1'b0;
    cycles(D + 6);
    lat = step_cyc - t0;
    check_eq("step_held_count", step_cnt, 1);
    check_eq("step_latency_7_to_8", 32'(lat >= 7 && lat <= 8), 1);

    // bouncing step button never qualifies
    step_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn[1] = ~btn[1];
      cycles(1);
    end
    btn[1] = 1'b0;
    cycles(12);
    check_eq("bounce_no_step", step_cnt, 0);

    // run toggles; step ignored while running
    press(0);
    check_eq("run_toggle_off", debug_en, 0);
    step_cnt = 0;
    press(1);
    check_eq("step_ignored_run", step_cnt, 0);
    press(0);
    check_eq("run_toggle_on", debug_en, 1);

    // address wrap both ways, and inc+dec together cancel
    press(4);
    check_eq("addr_dec_wrap", debug_addr, 127);
    press(3);
    check_eq("addr_inc_wrap", debug_addr, 0);
    press(3);
    check_eq("addr_inc", debug_addr, 1);
    btn[3] = 1'b1; btn[4] = 1'b1;
    cycles(12);
    btn[3] = 1'b0; btn[4] = 1'b0;
    cycles(D + 6);
    check_eq("addr_inc_dec_same", debug_addr, 1);

    // interrupter set, held, set-with-ack, then ack alone
    press(2);
    check_eq("irq_set", interrupter, 1);
    cycles(50);
    check_eq("irq_held_50", interrupter, 1);
    btn[2] = 1'b1;
    cycles(7);
    irq_ack = 1'b1;
    cycles(1);
    irq_ack = 1'b0;
    check_eq("irq_set_beats_ack", interrupter, 1);
    cycles(4);
    btn[2] = 1'b0;
    cycles(D + 6);
    irq_ack = 1'b1;
    cycles(1);
    irq_ack = 1'b0;
    check_eq("irq_ack_clears", interrupter, 0);

    // reset in the middle of an irq debounce; held button must re-qualify
    btn[2] = 1'b1;
    cycles(4);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    check_eq("midreset_state", {debug_en, debug_step, debug_addr, interrupter}, 32'h200);
    cycles(7);
    check_eq("midreset_no_early_irq", interrupter, 0);
    cycles(1);
    check_eq("midreset_irq_after_requal", interrupter, 1);
    btn[2] = 1'b0;
    cycles(D + 6);

    // random button activity, acks and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(40) == 0) begin
        btn[3] = ~btn[3];
        btn[4] = btn[3];
      end
      for (int b = 0; b < 5; b++)
        if ($urandom_range(11) == 0) btn[b] = ~btn[b];
      irq_ack = ($urandom_range(7) == 0);
      rst = ($urandom_range(299) != 0);
      cycles(1);
    end
    rst = 1'b1;
    irq_ack = 1'b0;
    btn = '0;
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
